// File: rtl/data_pipe_interconnect_m2s_rr_pkg.sv
// Shared types and helpers for the many-to-one data pipe merge stage.
// Optional build macro handled elsewhere: DATA_PIPE_M2S_FIXED_PRI_EN.
package data_pipe_interconnect_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } M2S_STATUS;

  // Increment an index, wrapping from num-1 back to 0.
  function automatic int next_idx(input int idx, input int num);
    return (idx >= num - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/data_pipe_interconnect_m2s_rr_if.sv
// Valid/ready data stream interface shared by the merge stage ports.
// A beat transfers on a clock edge where valid and ready are both high; the
// master holds valid and data stable until that happens, and ready may
// depend combinationally on valid.
interface data_inf #(
  parameter int DSIZE = 8
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_interconnect_m2s_rr_arbiter.sv
// Request arbiter for the merge stage: round-robin by default, fixed priority
// (lowest index wins) when DATA_PIPE_M2S_FIXED_PRI_EN is defined.
module data_pipe_rr_arbiter
  import data_pipe_interconnect_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int NSIZE = $clog2(NUM)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [NUM-1:0]   req,
  input  logic             advance,
  output logic [NUM-1:0]   grant,
  output logic [NSIZE-1:0] grant_idx
);

`ifdef DATA_PIPE_M2S_FIXED_PRI_EN
  logic unused_ok;
  assign unused_ok = ^{clock, rst_n, advance};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req[i]) grant_idx = NSIZE'(i);
    end
    if (|req) grant[grant_idx] = 1'b1;
  end
`else
  logic [NSIZE-1:0] rr_ptr_q;

  // Search starts just after the last winner so every requester is reached.
  always_comb begin
    logic [NSIZE-1:0] idx;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = rr_ptr_q;
    for (int k = 0; k < NUM; k++) begin
      idx = NSIZE'(next_idx(int'(idx), NUM));
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)       rr_ptr_q <= NSIZE'(NUM - 1);
    else if (advance) rr_ptr_q <= grant_idx;
  end
`endif

endmodule

// File: rtl/data_pipe_interconnect_m2s_rr.sv
// Many-to-one merge: NUM upstream streams arbitrated onto one registered
// output with a skid entry. Build macro: DATA_PIPE_M2S_FIXED_PRI_EN.
module data_pipe_interconnect_m2s_rr
  import data_pipe_interconnect_pkg::*;
#(
  parameter int NUM   = 8,
  parameter int DSIZE = 8,
  parameter int NSIZE = $clog2(NUM)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  data_inf.slaver          s00 [NUM-1:0],
  data_inf.master          m00,
  output logic [NSIZE-1:0] curr_path,
  output M2S_STATUS        state_o
);

  logic [NUM-1:0]   s_valid;
  logic [NUM-1:0]   s_ready;
  logic [DSIZE-1:0] s_data [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_port
    assign s_valid[g]    = s00[g].valid;
    assign s_data[g]     = s00[g].data;
    assign s00[g].ready  = s_ready[g];
  end

  M2S_STATUS        state_q, state_d;
  logic [DSIZE-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [NSIZE-1:0] main_src_q, main_src_d, skid_src_q, skid_src_d;
  logic             armed_q;
  logic [NUM-1:0]   grant;
  logic [NSIZE-1:0] grant_idx;
  logic             accept, up_hs, dn_hs;
  logic [DSIZE-1:0] up_data;

  data_pipe_rr_arbiter #(.NUM(NUM), .NSIZE(NSIZE)) u_arb (
    .clock     (clock),
    .rst_n     (rst_n),
    .req       (s_valid),
    .advance   (up_hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // armed_q keeps every ready low for the first clock after reset release.
  assign accept  = clk_en && (state_q != FULL) && armed_q;
  assign s_ready = accept ? grant : '0;
  assign up_hs   = |(s_valid & s_ready);
  assign dn_hs   = clk_en && m00.valid && m00.ready;
  assign up_data = s_data[grant_idx];

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;
    if (clk_en) begin
      case (state_q)
        EMPTY: if (up_hs) begin
          state_d     = ONE;
          main_data_d = up_data;
          main_src_d  = grant_idx;
        end
        ONE: if (up_hs && dn_hs) begin
          main_data_d = up_data;
          main_src_d  = grant_idx;
        end else if (up_hs) begin
          state_d     = FULL;
          skid_data_d = up_data;
          skid_src_d  = grant_idx;
        end else if (dn_hs) begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_src_d  = '0;
        end
        FULL: if (dn_hs) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_src_d  = skid_src_q;
          skid_data_d = '0;
          skid_src_d  = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      armed_q     <= 1'b1;
    end
  end

  assign m00.valid = (state_q != EMPTY);
  assign m00.data  = m00.valid ? main_data_q : '0;
  assign curr_path = m00.valid ? main_src_q : '0;
  assign state_o   = state_q;

endmodule

// File: tb/tb_data_pipe_interconnect_m2s_rr.sv
// Randomized bench for the merge stage: an occupancy/pointer model predicts
// ready, state and the merged beat stream, a monitor checks the output.
module tb_data_pipe_interconnect_m2s_rr;
  import data_pipe_interconnect_pkg::*;

  localparam int NUM   = 8;
  localparam int DSIZE = 8;
  localparam int NSIZE = 3;

  logic clock  = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_en = 1'b0;
  always #5 clock = ~clock;

  data_inf #(.DSIZE(DSIZE)) s_if [NUM-1:0] ();
  data_inf #(.DSIZE(DSIZE)) m_if ();

  logic [NUM-1:0]   tb_valid;
  logic [NUM-1:0]   tb_ready;
  logic [DSIZE-1:0] tb_data [NUM];
  logic             m_ready;
  logic [NSIZE-1:0] curr_path;
  M2S_STATUS        state_o;

  for (genvar g = 0; g < NUM; g++) begin : g_drv
    assign s_if[g].valid = tb_valid[g];
    assign s_if[g].data  = tb_data[g];
    assign tb_ready[g]   = s_if[g].ready;
  end
  assign m_if.ready = m_ready;

  data_pipe_interconnect_m2s_rr #(.NUM(NUM), .DSIZE(DSIZE), .NSIZE(NSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .s00       (s_if),
    .m00       (m_if),
    .curr_path (curr_path),
    .state_o   (state_o)
  );

  // Reference model: per-source pending beat, output occupancy, last winner.
  logic [NSIZE+DSIZE-1:0] exp_q[$];
  logic [DSIZE-1:0]       fixed_q[$];
  logic [NUM-1:0]         pend;
  logic [DSIZE-1:0]       pdata [NUM];
  int                     fixed_src;
  int                     cnt;
  int                     ptr;
  bit                     ready_en;
  int                     n_checks = 0;
  int                     n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [NUM-1:0] mask, input int offer_pct,
                       input int rdy_pct, input int en_pct);
    int             win;
    logic [NUM-1:0] exp_rdy;
    bit             acc, dn;
    @(negedge clock);
    if (fixed_q.size() > 0 && !pend[fixed_src]) begin
      pend[fixed_src]  = 1'b1;
      pdata[fixed_src] = fixed_q.pop_front();
    end
    for (int i = 0; i < NUM; i++) begin
      if (!pend[i] && mask[i] && ($urandom_range(99) < offer_pct)) begin
        pend[i]  = 1'b1;
        pdata[i] = DSIZE'($urandom);
      end
      tb_data[i] = pdata[i];
    end
    tb_valid = pend;
    m_ready  = ($urandom_range(99) < rdy_pct);
    clk_en   = ($urandom_range(99) < en_pct);
    #1;
    acc = clk_en && (cnt < 2) && ready_en;
    win = -1;
    if (acc) begin
      for (int k = 1; k <= NUM; k++) begin
        int j;
`ifdef DATA_PIPE_M2S_FIXED_PRI_EN
        j = k - 1;
`else
        j = (ptr + k) % NUM;
`endif
        if (win < 0 && pend[j]) win = j;
      end
    end
    exp_rdy = (win >= 0) ? (NUM'(1) << win) : '0;
    chk("ready", 32'(tb_ready), 32'(exp_rdy));
    chk("m_valid", 32'(m_if.valid), 32'(cnt > 0));
    chk("state", 32'(state_o), 32'(cnt));
    if (cnt == 0) begin
      chk("idle_data", 32'(m_if.data), 32'(0));
      chk("idle_path", 32'(curr_path), 32'(0));
    end
    dn = clk_en && (cnt > 0) && m_ready;
    if (win >= 0) begin
      exp_q.push_back({NSIZE'(win), pdata[win]});
      pend[win] = 1'b0;
      ptr       = win;
      cnt++;
    end
    if (dn) cnt--;
    ready_en = 1'b1;
  endtask

  // Monitor: a downstream transfer is due at the coming edge.
  initial begin
    logic [NSIZE+DSIZE-1:0] e;
    forever begin
      @(negedge clock);
      #2;
      if (rst_n && clk_en && m_if.valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(m_if.data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(m_if.data), 32'(e[DSIZE-1:0]));
          chk("out_src", 32'(curr_path), 32'(e[DSIZE +: NSIZE]));
        end
      end
    end
  end

  initial begin
    int guard;
    tb_valid  = '0;
    m_ready   = 1'b0;
    pend      = '0;
    for (int i = 0; i < NUM; i++) begin
      pdata[i]   = '0;
      tb_data[i] = '0;
    end
    fixed_src = 3;
    cnt       = 0;
    ptr       = NUM - 1;
    ready_en  = 1'b0;

    #3;
    chk("rst_valid", 32'(m_if.valid), 32'(0));
    chk("rst_data", 32'(m_if.data), 32'(0));
    chk("rst_path", 32'(curr_path), 32'(0));
    chk("rst_ready", 32'(tb_ready), 32'(0));
    chk("rst_state", 32'(state_o), 32'(EMPTY));
    @(posedge clock);
    #2 rst_n = 1'b1;

    // Single source, three back-to-back beats
    fixed_q = '{8'h11, 8'h22, 8'h33};
    repeat (8) cycle('0, 0, 100, 100);

    // All sources valid: round-robin rotation
    repeat (40) cycle('1, 100, 100, 100);

    // Back-pressure, then release
    repeat (6) cycle('1, 100, 0, 100);
    repeat (12) cycle('1, 100, 100, 100);

    // clk_en gap mid-burst
    repeat (3) cycle('1, 100, 100, 100);
    repeat (3) cycle('1, 100, 100, 0);
    repeat (6) cycle('1, 100, 100, 100);

    // Two competing sources
    repeat (30) cycle(NUM'(8'b0010_0100), 100, 100, 100);

    // Random traffic
    repeat (1500) cycle(NUM'($urandom), 50, 70, 90);

    // Fill up, then reset asynchronously between edges
    guard = 0;
    while (cnt < 2 && guard < 20) begin
      cycle('1, 100, 0, 100);
      guard++;
    end
    @(negedge clock);
    #2;
    chk("full_before_rst", 32'(state_o), 32'(FULL));
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(m_if.valid), 32'(0));
    chk("async_path", 32'(curr_path), 32'(0));
    chk("async_ready", 32'(tb_ready), 32'(0));
    cnt      = 0;
    ptr      = NUM - 1;
    ready_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #2 rst_n = 1'b1;
    repeat (20) cycle('1, 100, 100, 100);

    // Drain everything still pending
    repeat (24) cycle('0, 0, 100, 100);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_pipe_interconnect_m2s_rr.md
Name: data_pipe_interconnect_M2S_rr

Overview:
- Many-to-one merge stage: NUM data_inf slaver ports are round-robin arbitrated into one data_inf master port.
- It is the upstream complement of the S2M split stage; the merged stream feeds a single consumer (e.g. an S2M splitter or a FIFO).
- Registered output with a 2-entry skid buffer, so it sustains 1 beat/clock under back-pressure.

Parameters:
- NUM, 8, number of upstream (slaver) ports; legal 2..64.
- NSIZE, $clog2(NUM), width of the source index.

Ports:
- clock  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- clk_en  input  1  global enable; when low, no state, grant or buffer changes and no handshakes complete.
- s00  data_inf.slaver [NUM-1:0]  -  upstream ports (valid/ready/data, DSIZE from interface).
- m00  data_inf.master  -  merged downstream port.
- curr_path  output  NSIZE  source index of the beat currently on m00.

Behaviour:
- Reset (rst_n low, async) clears state:
  - FSM=EMPTY, m00.valid=0, m00.data='0, curr_path=0.
  - All s00[i].ready=0, rr pointer=NUM-1 (so index 0 wins first).
- Storage: main reg (data, src, vld) drives m00; skid reg (data, src, vld) behind it.
- FSM states (held in shared package enum):
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- accept = clk_en && state!=FULL; grant one-hot comes from the arbiter; s00[i].ready = accept && grant[i]; at most one ready high per cycle.
- up_hs = |(s00.valid & s00.ready); dn_hs = clk_en && m00.valid && m00.ready.
- Transitions (only when clk_en=1; otherwise hold):
  - EMPTY: up_hs -> ONE, main<=input beat.
  - ONE:
    - up_hs && dn_hs -> ONE, main<=input.
    - up_hs && !dn_hs -> FULL, skid<=input.
    - !up_hs && dn_hs -> EMPTY.
  - FULL: no upstream ready; dn_hs -> ONE, main<=skid, skid cleared.
  - Unknown encoding -> EMPTY.
- Latency: input handshake at cycle N -> m00.valid at N+1. Throughput is 1 beat/clock when m00.ready is held high.
- Arbitration:
  - Round-robin: search from rr_ptr+1 upward with wrap at NUM-1 -> 0; first valid source wins.
  - rr_ptr updates to the winning index only on up_hs; without a handshake the pointer holds, but the grant may move to another valid source.
  - No valid inputs -> grant=0, all ready low.
- Data ordering:
  - Beats from one source leave in arrival order.
  - Cross-source order equals grant order.
  - No beat is dropped or duplicated.
- m00.data is '0 whenever m00.valid=0; curr_path = main.src, and 0 when empty.
- Simultaneous events:
  - In FULL with dn_hs, no upstream beat is taken in that cycle.
  - In ONE, an up_hs and dn_hs in the same cycle are both honoured.
- clk_en low mid-transfer: all regs freeze, ready forced low, m00.valid holds its value.
- Reset mid-operation discards buffered beats; no ready pulses for one clock after release.

Optional Feature:
- Macro: DATA_PIPE_M2S_FIXED_PRI_EN.
- Defined: arbitration is fixed priority, lowest index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- The handshake, latency and buffer behaviour are identical in both builds.

Decomposition:
- Package data_pipe_interconnect_pkg holds:
  - typedef enum M2S_STATUS {EMPTY, ONE, FULL}.
  - Function for next-index wrap.
- Sub-module data_pipe_rr_arbiter #(NUM):
  - Inputs: clock, rst_n, req[NUM], advance.
  - Outputs: grant one-hot, grant_idx.
  - Contains rr_ptr and the macro switch.
- The top keeps the FSM, main/skid registers and interface mapping.

Test Plan:
- Single source: s00[3] sends 0x11,0x22,0x33 back-to-back with m00.ready=1 -> m00 shows the same beats on cycles N+1..N+3, curr_path=3, s00[3].ready stays high.
- Fairness: all 8 sources valid continuously, m00.ready=1 -> output src sequence 0,1,2,…,7,0; each source gets exactly 1 beat per 8 clocks.
- Back-pressure: drop m00.ready while a stream flows -> FSM reaches FULL after 1 extra beat and all ready go low. Raise m00.ready -> both buffered beats emerge in order, then the stream resumes with no loss.
- clk_en gated low for 3 cycles mid-burst -> no handshakes, outputs frozen; on re-enable the sequence continues unchanged.
- Async reset asserted between clock edges while FULL -> m00.valid drops immediately, curr_path=0. After release the first grant goes to source 0 (RR build).
- DATA_PIPE_M2S_FIXED_PRI_EN build, sources 2 and 5 both continuously valid -> only source 2 is served until it deasserts valid.
